m_multi_digit_counter: RTL and testbench

- Parametrised multi-digit, radix-N up/down counter; next generation of the single-digit universal counter.
- Cascades P_DIGITS identical digit stages, each counting 0..P_BASE-1.
- Adds direction control, synchronous parallel load, synchronous clear, and a combinational terminal-count/carry output for chaining further instances.
- Sits between debounced pushbutton/tick sources and the 7-segment display driver.

---
 rtl/counter_pkg.sv | 24 ++
 rtl/m_counter_digit.sv | 56 +++++
 rtl/m_multi_digit_counter.sv | 59 +++++
 tb/tb_m_multi_digit_counter.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared defaults, digit type and helpers for the multi-digit radix counter.
// Imported by the digit stage and the cascaded top level.
package counter_pkg;

    // Default geometry: four decimal digits, one nibble per digit.
    localparam int P_BASE_DEF        = 10;
    localparam int P_DIGITS_DEF      = 4;
    localparam int P_DIGIT_WIDTH_DEF = 4;

    typedef logic [P_DIGIT_WIDTH_DEF-1:0] t_digit;

    // Clamp a loaded digit into the legal range 0..base-1 so that an
    // out-of-range nibble can never enter the digit register.
    function automatic int unsigned f_saturate_digit(
        input int unsigned value,
        input int unsigned base
    );
        if (value >= base) begin
            return base - 1;
        end
        return value;
    endfunction

endpackage

// File: rtl/m_counter_digit.sv
// One radix-P_BASE digit register with clear, load and up/down stepping.
// Ports: clk, reset (sync, active-high), clear, load, load_digit, en, up_dn
//        in; q (digit value), at_max (q == P_BASE-1), at_zero (q == 0) out.
module m_counter_digit
    import counter_pkg::*;
#(
    parameter int P_BASE        = P_BASE_DEF,
    parameter int P_DIGIT_WIDTH = P_DIGIT_WIDTH_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     load,
    input  logic [P_DIGIT_WIDTH-1:0] load_digit,
    input  logic                     en,
    input  logic                     up_dn,
    output logic [P_DIGIT_WIDTH-1:0] q,
    output logic                     at_max,
    output logic                     at_zero
);

    localparam logic [P_DIGIT_WIDTH-1:0] DIGIT_MAX = P_DIGIT_WIDTH'(P_BASE - 1);
    localparam logic [P_DIGIT_WIDTH-1:0] DIGIT_ONE = P_DIGIT_WIDTH'(1);

    logic [P_DIGIT_WIDTH-1:0] load_sat;
    logic [P_DIGIT_WIDTH-1:0] step_val;

    assign load_sat = P_DIGIT_WIDTH'(
        f_saturate_digit(32'(load_digit), 32'(P_BASE)));

    assign at_max  = (q == DIGIT_MAX);
    assign at_zero = (q == '0);

    // Wrap at the radix boundaries in either direction.
    always_comb begin
        step_val = q;
        if (up_dn) begin
            step_val = at_max ? '0 : q + DIGIT_ONE;
        end else begin
            step_val = at_zero ? DIGIT_MAX : q - DIGIT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (clear) begin
            q <= '0;
        end else if (load) begin
            q <= load_sat;
        end else if (en) begin
            q <= step_val;
        end
    end

endmodule

// File: rtl/m_multi_digit_counter.sv
// Cascaded radix-P_BASE up/down counter of P_DIGITS digits with load/clear.
// Ports: clk, reset, c_in, up_dn, clear, load, load_value in; q, c_out, is_zero out.
module m_multi_digit_counter
    import counter_pkg::*;
#(
    parameter int P_BASE        = P_BASE_DEF,
    parameter int P_DIGITS      = P_DIGITS_DEF,
    parameter int P_DIGIT_WIDTH = P_DIGIT_WIDTH_DEF
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              c_in,
    input  logic                              up_dn,
    input  logic                              clear,
    input  logic                              load,
    input  logic [P_DIGITS*P_DIGIT_WIDTH-1:0] load_value,
    output logic [P_DIGITS*P_DIGIT_WIDTH-1:0] q,
    output logic                              c_out,
    output logic                              is_zero
);

    logic [P_DIGITS-1:0] at_max;
    logic [P_DIGITS-1:0] at_zero;
    logic [P_DIGITS-1:0] pass;
    logic [P_DIGITS:0]   ripple;

    // ripple[k] enables digit k: the count request propagated through every
    // lower digit that sits at its wrap value for the current direction.
    // The final tap is the carry/borrow to a following instance.
    assign ripple[0] = c_in;

    genvar k;
    generate
        for (k = 0; k < P_DIGITS; k++) begin : g_digit
            assign pass[k]       = up_dn ? at_max[k] : at_zero[k];
            assign ripple[k + 1] = ripple[k] & pass[k];

            m_counter_digit #(
                .P_BASE        (P_BASE),
                .P_DIGIT_WIDTH (P_DIGIT_WIDTH)
            ) u_digit (
                .clk        (clk),
                .reset      (reset),
                .clear      (clear),
                .load       (load),
                .load_digit (load_value[k*P_DIGIT_WIDTH +: P_DIGIT_WIDTH]),
                .en         (ripple[k]),
                .up_dn      (up_dn),
                .q          (q[k*P_DIGIT_WIDTH +: P_DIGIT_WIDTH]),
                .at_max     (at_max[k]),
                .at_zero    (at_zero[k])
            );
        end
    endgenerate

    assign c_out   = ripple[P_DIGITS];
    assign is_zero = &at_zero;

endmodule

// File: tb/tb_m_multi_digit_counter.sv
// Directed bench for m_multi_digit_counter: decimal 4-digit and base-9
// single-digit instances checked against hand-computed vectors.
module tb_m_multi_digit_counter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_a, c_in_a, up_dn_a, clear_a, load_a;
    logic [15:0] load_value_a;
    logic [15:0] q_a;
    logic        c_out_a, is_zero_a;

    logic        reset_b, c_in_b, up_dn_b, clear_b, load_b;
    logic [3:0]  load_value_b;
    logic [3:0]  q_b;
    logic        c_out_b, is_zero_b;

    int n_vec = 0;
    int n_err = 0;

    m_multi_digit_counter #(
        .P_BASE(10), .P_DIGITS(4), .P_DIGIT_WIDTH(4)
    ) u_dut_a (
        .clk(clk), .reset(reset_a), .c_in(c_in_a), .up_dn(up_dn_a),
        .clear(clear_a), .load(load_a), .load_value(load_value_a),
        .q(q_a), .c_out(c_out_a), .is_zero(is_zero_a)
    );

    m_multi_digit_counter #(
        .P_BASE(9), .P_DIGITS(1), .P_DIGIT_WIDTH(4)
    ) u_dut_b (
        .clk(clk), .reset(reset_b), .c_in(c_in_b), .up_dn(up_dn_b),
        .clear(clear_b), .load(load_b), .load_value(load_value_b),
        .q(q_b), .c_out(c_out_b), .is_zero(is_zero_b)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_val_a(input logic [15:0] v);
        load_a = 1'b1; load_value_a = v; c_in_a = 1'b0;
        step();
        load_a = 1'b0;
    endtask

    initial begin
        reset_a = 1'b1; c_in_a = 1'b1; up_dn_a = 1'b1;
        clear_a = 1'b0; load_a = 1'b0; load_value_a = '0;
        reset_b = 1'b1; c_in_b = 1'b0; up_dn_b = 1'b1;
        clear_b = 1'b0; load_b = 1'b0; load_value_b = '0;

        repeat (100) step();
        chk("rst_q", q_a, 32'h0000);
        chk("rst_zero", is_zero_a, 1);
        chk("rst_cout", c_out_a, 0);

        reset_a = 1'b0;
        repeat (9) step();
        chk("up9_q", q_a, 32'h0009);
        chk("up9_cout", c_out_a, 0);
        chk("up9_zero", is_zero_a, 0);

        step();
        chk("up10_q", q_a, 32'h0010);

        load_val_a(16'h0999);
        chk("ld999_q", q_a, 32'h0999);
        c_in_a = 1'b0;
        step();
        chk("hold_q", q_a, 32'h0999);
        c_in_a = 1'b1;
        step();
        chk("ripple_up_q", q_a, 32'h1000);

        load_val_a(16'h9999);
        c_in_a = 1'b0; #1;
        chk("cout_noen", c_out_a, 0);
        c_in_a = 1'b1; up_dn_a = 1'b1; #1;
        chk("cout_up", c_out_a, 1);
        step();
        chk("wrap_up_q", q_a, 32'h0000);
        chk("wrap_up_zero", is_zero_a, 1);

        up_dn_a = 1'b0; #1;
        chk("cout_dn", c_out_a, 1);
        step();
        chk("wrap_dn_q", q_a, 32'h9999);
        chk("wrap_dn_zero", is_zero_a, 0);

        load_val_a(16'h1000);
        c_in_a = 1'b1; up_dn_a = 1'b0;
        step();
        chk("ripple_dn_q", q_a, 32'h0999);
        up_dn_a = 1'b1;
        step();
        chk("dir_chg_q", q_a, 32'h1000);

        load_val_a(16'h1C3F);
        chk("sat_ld_q", q_a, 32'h1939);

        clear_a = 1'b1; load_a = 1'b1; load_value_a = 16'h1234;
        step();
        chk("clr_ld_q", q_a, 32'h0000);
        clear_a = 1'b0;
        step();
        chk("ld_after_q", q_a, 32'h1234);
        reset_a = 1'b1; load_value_a = 16'h5678;
        step();
        chk("rst_ld_q", q_a, 32'h0000);
        reset_a = 1'b0; load_a = 1'b0; c_in_a = 1'b0;

        reset_b = 1'b0; c_in_b = 1'b1; up_dn_b = 1'b1;
        repeat (8) step();
        chk("b9_up8_q", q_b, 32'h8);
        chk("b9_cout", c_out_b, 1);
        step();
        chk("b9_wrap_q", q_b, 32'h0);
        chk("b9_wrap_zero", is_zero_b, 1);
        repeat (3) step();
        c_in_b = 1'b0;
        repeat (20) step();
        chk("b9_hold_q", q_b, 32'h3);
        chk("b9_hold_cout", c_out_b, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
